// File: rtl/l2_req_arbiter.sv
// Round-robin arbiter sharing the L2 request channel between the D-cache and I-cache.
// Each requester has its own FIFO; all outputs come straight from flops.
module l2_req_arbiter #(
  parameter int ADDR_W = 26,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        d_cmd,
  input  logic [ADDR_W-1:0] d_add,
  input  logic [1:0]        i_cmd,
  input  logic [ADDR_W-1:0] i_add,
  output logic              d_full,
  output logic              i_full,
  output logic              l2_valid,
  output logic [1:0]        l2_cmd,
  output logic [ADDR_W-1:0] l2_add,
  output logic              l2_src,
  input  logic              l2_ready,
  output logic [CNT_W-1:0]  d_grants,
  output logic [CNT_W-1:0]  i_grants,
  output logic [CNT_W-1:0]  drops
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = ADDR_W + 2;

  typedef enum logic [1:0] {IDLE, GNT_D, GNT_I} state_t;

  state_t r_state, w_state_nxt;

  // Index 0 is the data side, index 1 the instruction side.
  logic [1:0]        w_cmd  [2];
  logic [ADDR_W-1:0] w_add  [2];
  logic [EW-1:0]     r_mem  [2][DEPTH];
  logic [AW-1:0]     r_rd   [2];
  logic [AW-1:0]     r_wr   [2];
  logic [CW-1:0]     r_cnt  [2];
  logic [CW-1:0]     w_cnt_nxt [2];
  logic              r_full [2];
  logic              w_req  [2];
  logic              w_push [2];
  logic              w_drop [2];
  logic              w_pop  [2];
  logic              w_ne   [2];
  logic [EW-1:0]     w_head [2];

  logic              w_busy;
  logic              r_prio_i;
  logic              r_l2_valid;
  logic [1:0]        r_l2_cmd;
  logic [ADDR_W-1:0] r_l2_add;
  logic              r_l2_src;
  logic [CNT_W-1:0]  r_d_grants;
  logic [CNT_W-1:0]  r_i_grants;
  logic [CNT_W-1:0]  r_drops;

  assign w_cmd[0] = d_cmd;
  assign w_cmd[1] = i_cmd;
  assign w_add[0] = d_add;
  assign w_add[1] = i_add;

  assign w_pop[0] = (r_state == GNT_D) && l2_ready;
  assign w_pop[1] = (r_state == GNT_I) && l2_ready;

  // Arbitration looks at contents after this edge's pop but ignores same-edge pushes,
  // so a newly pushed entry is only considered one edge later.
  always_comb begin
    for (int unsigned s = 0; s < 2; s++) begin
      w_req[s]  = (w_cmd[s] == 2'b01) || (w_cmd[s] == 2'b10);
      w_push[s] = w_req[s] && !r_full[s];
      w_drop[s] = w_req[s] && r_full[s];
      w_ne[s]   = (r_cnt[s] != '0) && !(w_pop[s] && (r_cnt[s] == CW'(1)));
      w_head[s] = w_pop[s] ? r_mem[s][r_rd[s] + AW'(1)] : r_mem[s][r_rd[s]];
      case ({w_push[s], w_pop[s]})
        2'b10:   w_cnt_nxt[s] = r_cnt[s] + CW'(1);
        2'b01:   w_cnt_nxt[s] = r_cnt[s] - CW'(1);
        default: w_cnt_nxt[s] = r_cnt[s];
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = !((r_state == GNT_D) || (r_state == GNT_I)) || w_pop[0] || w_pop[1];
    if (w_busy) begin
      if (w_ne[0] && w_ne[1])
        w_state_nxt = r_prio_i ? GNT_I : GNT_D;
      else if (w_ne[0])
        w_state_nxt = GNT_D;
      else if (w_ne[1])
        w_state_nxt = GNT_I;
      else
        w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned s = 0; s < 2; s++)
      if (w_push[s]) r_mem[s][r_wr[s]] <= {w_cmd[s], w_add[s]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < 2; s++) begin
        r_rd[s]   <= '0;
        r_wr[s]   <= '0;
        r_cnt[s]  <= '0;
        r_full[s] <= 1'b0;
      end
    end else begin
      for (int unsigned s = 0; s < 2; s++) begin
        if (w_push[s]) r_wr[s] <= r_wr[s] + AW'(1);
        if (w_pop[s])  r_rd[s] <= r_rd[s] + AW'(1);
        r_cnt[s]  <= w_cnt_nxt[s];
        r_full[s] <= (w_cnt_nxt[s] == CW'(DEPTH));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_prio_i   <= 1'b0;
      r_l2_valid <= 1'b0;
      r_l2_cmd   <= '0;
      r_l2_add   <= '0;
      r_l2_src   <= 1'b0;
      r_d_grants <= '0;
      r_i_grants <= '0;
      r_drops    <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (w_state_nxt)
        GNT_D: begin
          r_prio_i               <= 1'b1;
          r_l2_valid             <= 1'b1;
          {r_l2_cmd, r_l2_add}   <= w_head[0];
          r_l2_src               <= 1'b0;
        end
        GNT_I: begin
          r_prio_i               <= 1'b0;
          r_l2_valid             <= 1'b1;
          {r_l2_cmd, r_l2_add}   <= w_head[1];
          r_l2_src               <= 1'b1;
        end
        default: begin
          r_l2_valid <= 1'b0;
          r_l2_cmd   <= '0;
          r_l2_add   <= '0;
          r_l2_src   <= 1'b0;
        end
      endcase
      if (w_pop[0]) r_d_grants <= r_d_grants + CNT_W'(1);
      if (w_pop[1]) r_i_grants <= r_i_grants + CNT_W'(1);
      r_drops <= r_drops + CNT_W'(w_drop[0]) + CNT_W'(w_drop[1]);
    end
  end

  assign d_full   = r_full[0];
  assign i_full   = r_full[1];
  assign l2_valid = r_l2_valid;
  assign l2_cmd   = r_l2_cmd;
  assign l2_add   = r_l2_add;
  assign l2_src   = r_l2_src;
  assign d_grants = r_d_grants;
  assign i_grants = r_i_grants;
  assign drops    = r_drops;

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Directed bench for l2_req_arbiter: per-source queues hold expected entries,
// checked against the presented request every cycle and popped on each handshake.
module tb_l2_req_arbiter;

  localparam int ADDR_W = 26;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 32;

  logic              clk;
  logic              rst_n;
  logic [1:0]        d_cmd, i_cmd;
  logic [ADDR_W-1:0] d_add, i_add;
  logic              d_full, i_full;
  logic              l2_valid;
  logic [1:0]        l2_cmd;
  logic [ADDR_W-1:0] l2_add;
  logic              l2_src;
  logic              l2_ready;
  logic [CNT_W-1:0]  d_grants, i_grants, drops;

  int total = 0;
  int bad   = 0;
  int dg = 0, ig = 0, drp = 0;
  logic [ADDR_W+1:0] qd[$];
  logic [ADDR_W+1:0] qi[$];

  l2_req_arbiter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_cmd(d_cmd), .d_add(d_add), .i_cmd(i_cmd), .i_add(i_add),
    .d_full(d_full), .i_full(i_full),
    .l2_valid(l2_valid), .l2_cmd(l2_cmd), .l2_add(l2_add), .l2_src(l2_src),
    .l2_ready(l2_ready),
    .d_grants(d_grants), .i_grants(i_grants), .drops(drops)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("d_full", {63'd0, d_full}, {63'd0, qd.size() == DEPTH});
    chk("i_full", {63'd0, i_full}, {63'd0, qi.size() == DEPTH});
    chk("d_grants", 64'(d_grants), 64'(dg));
    chk("i_grants", 64'(i_grants), 64'(ig));
    chk("drops", 64'(drops), 64'(drp));
    if (l2_valid) begin
      if (!l2_src) begin
        if (qd.size() == 0) chk("stale_d", {63'd0, l2_valid}, 64'd0);
        else chk("head_d", 64'({l2_cmd, l2_add}), 64'(qd[0]));
      end else begin
        if (qi.size() == 0) chk("stale_i", {63'd0, l2_valid}, 64'd0);
        else chk("head_i", 64'({l2_cmd, l2_add}), 64'(qi[0]));
      end
    end else begin
      chk("idle_out", 64'({l2_src, l2_cmd, l2_add}), 64'd0);
    end
  endtask

  // Model one clock edge from the inputs currently driven, then sample 1ns after it.
  task automatic tick();
    bit fd, fi;
    fd = (qd.size() == DEPTH);
    fi = (qi.size() == DEPTH);
    if (l2_valid && l2_ready) begin
      if (!l2_src && qd.size() > 0) begin void'(qd.pop_front()); dg++; end
      if (l2_src && qi.size() > 0)  begin void'(qi.pop_front()); ig++; end
    end
    if (d_cmd == 2'b01 || d_cmd == 2'b10) begin
      if (fd) drp++; else qd.push_back({d_cmd, d_add});
    end
    if (i_cmd == 2'b01 || i_cmd == 2'b10) begin
      if (fi) drp++; else qi.push_back({i_cmd, i_add});
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    qd.delete(); qi.delete();
    dg = 0; ig = 0; drp = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; d_cmd = 2'b00; i_cmd = 2'b00; d_add = '0; i_add = '0; l2_ready = 1'b0;
    #2;
    do_reset();
    check_state();
    chk("rst_valid", {63'd0, l2_valid}, 64'd0);

    // Single read: valid one edge after the push edge, then one transfer
    d_cmd = 2'b01; d_add = 26'h0000ABC; l2_ready = 1'b1;
    tick();
    d_cmd = 2'b00;
    chk("lat_pre", {63'd0, l2_valid}, 64'd0);
    tick();
    chk("lat_valid", {63'd0, l2_valid}, 64'd1);
    chk("lat_req", 64'({l2_src, l2_cmd, l2_add}), 64'({1'b0, 2'b01, 26'h0000ABC}));
    tick();
    chk("lat_done", {63'd0, l2_valid}, 64'd0);
    chk("lat_grants", 64'(d_grants), 64'd1);

    // Round-robin from reset priority
    do_reset();
    l2_ready = 1'b0;
    d_cmd = 2'b01; i_cmd = 2'b10;
    d_add = 26'h1;  i_add = 26'h100; tick();
    d_add = 26'h2;  i_add = 26'h101; tick();
    d_cmd = 2'b00; i_cmd = 2'b00;
    l2_ready = 1'b1;
    chk("rr0", {62'd0, l2_valid, l2_src}, 64'b10);
    tick(); chk("rr1", {62'd0, l2_valid, l2_src}, 64'b11);
    tick(); chk("rr2", {62'd0, l2_valid, l2_src}, 64'b10);
    tick(); chk("rr3", {62'd0, l2_valid, l2_src}, 64'b11);
    tick(); chk("rr_end", {63'd0, l2_valid}, 64'd0);
    chk("rr_dg", 64'(d_grants), 64'd2);
    chk("rr_ig", 64'(i_grants), 64'd2);

    // Stall and hold
    l2_ready = 1'b0;
    i_cmd = 2'b10; i_add = 26'h3FFFFFF; tick();
    i_cmd = 2'b00; tick();
    for (int k = 0; k < 5; k++) begin
      chk("hold", 64'({l2_valid, l2_src, l2_cmd, l2_add}), 64'({1'b1, 1'b1, 2'b10, 26'h3FFFFFF}));
      tick();
    end
    l2_ready = 1'b1; tick();
    chk("stall_done", {63'd0, l2_valid}, 64'd0);
    chk("stall_ig", 64'(i_grants), 64'd3);
    tick();
    chk("stall_once", 64'(i_grants), 64'd3);

    // Overflow: 6 writes with L2 stalled, then push-while-full with a pop on the same edge
    l2_ready = 1'b0;
    d_cmd = 2'b10;
    for (int k = 0; k < 6; k++) begin
      d_add = 26'h10 + 26'(k);
      tick();
    end
    chk("ovf_full", {63'd0, d_full}, 64'd1);
    chk("ovf_drops", 64'(drops), 64'd2);
    d_cmd = 2'b01; d_add = 26'h99; l2_ready = 1'b1; tick();
    chk("ovf_popdrop", 64'(drops), 64'd3);
    chk("ovf_unfull", {63'd0, d_full}, 64'd0);
    d_cmd = 2'b00;
    for (int k = 0; k < 3; k++) tick();
    chk("ovf_drained", {63'd0, l2_valid}, 64'd0);

    // Both sides dropping on one edge
    l2_ready = 1'b0;
    d_cmd = 2'b01; i_cmd = 2'b01;
    for (int k = 0; k < 5; k++) begin
      d_add = 26'h200 + 26'(k); i_add = 26'h300 + 26'(k);
      tick();
    end
    chk("dual_drops", 64'(drops), 64'd5);
    d_cmd = 2'b00; i_cmd = 2'b00; l2_ready = 1'b1;
    for (int k = 0; k < 9; k++) tick();
    chk("dual_drained", {63'd0, l2_valid}, 64'd0);

    // Illegal and idle commands
    d_cmd = 2'b11; i_cmd = 2'b11;
    for (int k = 0; k < 10; k++) tick();
    chk("ill_valid", {63'd0, l2_valid}, 64'd0);
    chk("ill_drops", 64'(drops), 64'd5);
    d_cmd = 2'b00; i_cmd = 2'b00;

    // Reset mid-grant
    l2_ready = 1'b0;
    d_cmd = 2'b10; d_add = 26'h55; i_cmd = 2'b01; i_add = 26'h66; tick();
    d_cmd = 2'b00; i_cmd = 2'b00; tick();
    chk("mid_valid", {63'd0, l2_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {63'd0, l2_valid}, 64'd0);
    chk("arst_cnt", 64'({d_grants | i_grants | drops}), 64'd0);
    do_reset();
    l2_ready = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    chk("no_stale", {63'd0, l2_valid}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
